change_dispense_ctrl: RTL and testbench
=======================================

Name: change_dispense_ctrl

Overview:
Sequential controller that turns a change amount (cents) into a paced stream of single-coin eject requests to the coin mechanism. It selects denominations greedily: quarter (25), dime (10), nickel (5). It handshakes one coin at a time, keeps running per-denomination counts, and reports completion and error status. It sits between the vending transaction logic, which supplies the amount, and the physical coin hopper interface.

Parameters:
CHANGE_W, 32, width of change input and remaining-amount register
CNT_W, 9, width of per-denomination dispensed counters
INV_W, 8, width of coin inventory counters (used only with INVENTORY_EN)
MAX_CHANGE, 12775, largest accepted amount in cents (511 quarters)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request to dispense; sampled only in IDLE
change  input  CHANGE_W  amount in cents; captured on accepted start
coin_ack  input  1  mechanism has ejected the requested coin
load_inv  input  1  load inventory counters (INVENTORY_EN builds only)
inv_q, inv_d, inv_n  input  INV_W each  inventory load values
coin_req  output  1  eject request, held until coin_ack
coin_sel  output  2  01 quarter, 10 dime, 11 nickel, 00 idle
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse
quarters, dimes, nickels  output  CNT_W each  coins dispensed in current/last transaction
err_inexact  output  1  remainder 1-4 cents left undispensed
err_range  output  1  change > MAX_CHANGE, nothing dispensed
err_short  output  1  inventory exhausted before amount satisfied

Behaviour:
- Reset values: coin_req=0, coin_sel=00, busy=0, done=0, all counts=0, all err_*=0, state IDLE, remaining=0. Inventory counters reset to 0.
- States: IDLE, LOAD, SEL, REQ, FIN.
- IDLE:
  - start=1 captures change into remaining.
  - Clears counts and err_* flags; busy=1 next cycle; goes to LOAD.
- LOAD:
  - If remaining > MAX_CHANGE, set err_range and go to FIN.
  - Otherwise go to SEL.
- SEL, first match wins:
  - remaining>=25 and quarter available -> quarter.
  - Else remaining>=10 and dime available -> dime.
  - Else remaining>=5 and nickel available -> nickel.
  - Else go to FIN: err_inexact = (remaining!=0 and remaining<5); err_short = remaining>=5.
  - On a coin choice, drive coin_sel and coin_req=1 from the next cycle (REQ).
- REQ:
  - coin_req and coin_sel hold stable until coin_ack is sampled high.
  - On that edge: remaining -= coin value, matching count +1, matching inventory -1 (INVENTORY_EN only).
  - Same edge: coin_req drops to 0, coin_sel to 00, return to SEL.
  - Guarantees at least one low cycle between consecutive requests.
  - coin_ack outside REQ is ignored.
- FIN: done=1 for exactly one cycle, busy=0 on the same cycle, return to IDLE. Counts and err_* hold until the next accepted start.
- Latency:
  - coin_req rises 3 cycles after the start edge (LOAD, SEL, REQ).
  - Amount <5: done asserted 3 cycles after start.
  - With immediate ack, each coin costs 2 cycles.
- Start while busy is ignored. Counts cannot overflow because of the MAX_CHANGE check.
- rst at any time: next edge returns to IDLE with all reset values, including coin_req=0 mid-handshake. No done pulse.
- load_inv is accepted only in IDLE. When start and load_inv are both high in IDLE, load_inv takes effect and start is ignored that cycle.

Optional Feature:
INVENTORY_EN:
- Defined:
  - Three INV_W coin counters, loaded by load_inv.
  - A denomination is "available" only if its counter is nonzero.
  - Counters decrement on each acked coin; SEL falls back to smaller coins.
  - err_short is reported when remaining>=5 but no usable coin is left.
- Undefined:
  - All denominations are always available; inventory ports are ignored.
  - err_short is tied to 0.

Test Plan:
- change=65, coin_ack 1 cycle after each coin_req -> coin_sel sequence 01,01,10,11; quarters=2, dimes=1, nickels=1; one done pulse; all err_*=0.
- change=0 -> no coin_req; done 3 cycles after start; counts 0, err_inexact=0.
- change=33 -> coin_sel 01,11; quarters=1, nickels=1; err_inexact=1.
- change=30, coin_ack delayed 6 cycles -> coin_req and coin_sel=01 stable for 6 cycles; quarters=1 (not more); then coin_sel=11.
- change=12776 -> err_range=1, no coin_req, done pulse. Also rst asserted while coin_req=1 -> next cycle coin_req=0, busy=0, counts 0, no done.
- INVENTORY_EN with load inv_q=1, inv_d=0, inv_n=10, change=50 -> 1 quarter then 5 nickels, err_short=0. Reload q=0, d=0, n=1, change=20 -> 1 nickel, err_short=1.

Source files
------------

// File: rtl/change_dispense_ctrl.sv
// Greedy change dispenser: paces one coin eject request at a time (25/10/5 cents).
// Optional macro INVENTORY_EN adds per-denomination coin inventory with fallback and err_short.
`timescale 1ns/1ps
module change_dispense_ctrl #(
  parameter int CHANGE_W   = 32,
  parameter int CNT_W      = 9,
  parameter int INV_W      = 8,
  parameter int MAX_CHANGE = 12775
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CHANGE_W-1:0] change,
  input  logic                coin_ack,
  input  logic                load_inv,
  input  logic [INV_W-1:0]    inv_q,
  input  logic [INV_W-1:0]    inv_d,
  input  logic [INV_W-1:0]    inv_n,
  output logic                coin_req,
  output logic [1:0]          coin_sel,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    quarters,
  output logic [CNT_W-1:0]    dimes,
  output logic [CNT_W-1:0]    nickels,
  output logic                err_inexact,
  output logic                err_range,
  output logic                err_short
);

  typedef enum logic [2:0] {IDLE, LOAD, SEL, REQ, FIN} state_t;

  localparam logic [CHANGE_W-1:0] MAX_C = CHANGE_W'(MAX_CHANGE);
  localparam logic [CHANGE_W-1:0] Q_VAL = CHANGE_W'(25);
  localparam logic [CHANGE_W-1:0] D_VAL = CHANGE_W'(10);
  localparam logic [CHANGE_W-1:0] N_VAL = CHANGE_W'(5);

  localparam logic [1:0] SEL_Q = 2'b01;
  localparam logic [1:0] SEL_D = 2'b10;
  localparam logic [1:0] SEL_N = 2'b11;

  state_t              state, state_nxt;
  logic [CHANGE_W-1:0] remaining;
  logic [1:0]          sel_r, sel_nxt;
  logic                q_ok, d_ok, n_ok;
  logic                load_now;
  logic                accept;

  function automatic logic [CHANGE_W-1:0] coin_value(input logic [1:0] s);
    case (s)
      SEL_Q:   coin_value = Q_VAL;
      SEL_D:   coin_value = D_VAL;
      SEL_N:   coin_value = N_VAL;
      default: coin_value = '0;
    endcase
  endfunction

`ifdef INVENTORY_EN
  logic [INV_W-1:0] inv_q_cnt, inv_d_cnt, inv_n_cnt;

  assign q_ok     = (inv_q_cnt != '0);
  assign d_ok     = (inv_d_cnt != '0);
  assign n_ok     = (inv_n_cnt != '0);
  assign load_now = load_inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q_cnt <= '0;
      inv_d_cnt <= '0;
      inv_n_cnt <= '0;
      err_short <= 1'b0;
    end else begin
      if (state == IDLE && load_inv) begin
        inv_q_cnt <= inv_q;
        inv_d_cnt <= inv_d;
        inv_n_cnt <= inv_n;
      end else if (state == REQ && coin_ack) begin
        case (sel_r)
          SEL_Q:   inv_q_cnt <= inv_q_cnt - INV_W'(1);
          SEL_D:   inv_d_cnt <= inv_d_cnt - INV_W'(1);
          SEL_N:   inv_n_cnt <= inv_n_cnt - INV_W'(1);
          default: ;
        endcase
      end
      if (accept)
        err_short <= 1'b0;
      else if (state == SEL && state_nxt == FIN)
        err_short <= (remaining >= N_VAL);
    end
  end
`else
  logic unused_inv;

  assign q_ok       = 1'b1;
  assign d_ok       = 1'b1;
  assign n_ok       = 1'b1;
  assign load_now   = 1'b0;
  assign err_short  = 1'b0;
  assign unused_inv = ^{load_inv, inv_q, inv_d, inv_n};
`endif

  // A simultaneous inventory load takes priority over a start request.
  assign accept = (state == IDLE) && start && !load_now;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_r;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = (remaining > MAX_C) ? FIN : SEL;
      SEL: begin
        if (remaining >= Q_VAL && q_ok) begin
          sel_nxt   = SEL_Q;
          state_nxt = REQ;
        end else if (remaining >= D_VAL && d_ok) begin
          sel_nxt   = SEL_D;
          state_nxt = REQ;
        end else if (remaining >= N_VAL && n_ok) begin
          sel_nxt   = SEL_N;
          state_nxt = REQ;
        end else begin
          state_nxt = FIN;
        end
      end
      REQ:     if (coin_ack) state_nxt = SEL;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel_r       <= 2'b00;
      remaining   <= '0;
      quarters    <= '0;
      dimes       <= '0;
      nickels     <= '0;
      err_inexact <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      state <= state_nxt;
      sel_r <= sel_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            remaining   <= change;
            quarters    <= '0;
            dimes       <= '0;
            nickels     <= '0;
            err_inexact <= 1'b0;
            err_range   <= 1'b0;
          end
        end
        LOAD: if (remaining > MAX_C) err_range <= 1'b1;
        SEL: begin
          if (state_nxt == FIN)
            err_inexact <= (remaining != '0) && (remaining < N_VAL);
        end
        REQ: begin
          if (coin_ack) begin
            remaining <= remaining - coin_value(sel_r);
            case (sel_r)
              SEL_Q:   quarters <= quarters + CNT_W'(1);
              SEL_D:   dimes    <= dimes + CNT_W'(1);
              SEL_N:   nickels  <= nickels + CNT_W'(1);
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode straight from state so the SEL cycle always separates requests.
  assign coin_req = (state == REQ);
  assign coin_sel = (state == REQ) ? sel_r : 2'b00;
  assign busy     = (state == LOAD) || (state == SEL) || (state == REQ);
  assign done     = (state == FIN);

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Scoreboard bench for change_dispense_ctrl: directed and random amounts vs. an arithmetic model.
`timescale 1ns/1ps
module tb_change_dispense_ctrl;
  localparam int CHANGE_W   = 32;
  localparam int CNT_W      = 9;
  localparam int INV_W      = 8;
  localparam int MAX_CHANGE = 12775;

  logic                clk = 1'b0;
  logic                rst, start, coin_ack, load_inv;
  logic [CHANGE_W-1:0] change;
  logic [INV_W-1:0]    inv_q, inv_d, inv_n;
  logic                coin_req, busy, done;
  logic [1:0]          coin_sel;
  logic [CNT_W-1:0]    quarters, dimes, nickels;
  logic                err_inexact, err_range, err_short;

  change_dispense_ctrl #(
    .CHANGE_W(CHANGE_W), .CNT_W(CNT_W), .INV_W(INV_W), .MAX_CHANGE(MAX_CHANGE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .change(change), .coin_ack(coin_ack),
    .load_inv(load_inv), .inv_q(inv_q), .inv_d(inv_d), .inv_n(inv_n),
    .coin_req(coin_req), .coin_sel(coin_sel), .busy(busy), .done(done),
    .quarters(quarters), .dimes(dimes), .nickels(nickels),
    .err_inexact(err_inexact), .err_range(err_range), .err_short(err_short)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q, d, n;
    bit inexact, range, shrt;
  } res_t;

  res_t       exp_res[$];
  logic [1:0] exp_coins[$];
  int         n_cmp = 0, n_err = 0;
  int         mdl_q = 1 << 20, mdl_d = 1 << 20, mdl_n = 1 << 20;
  int         ack_dly = 0;
  bit         spurious = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event bound expired or unexpected event", name);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Greedy dispensing computed with division against the available inventory.
  task automatic model_txn(input int amt, output int lat);
    res_t r;
    int   rem;
    r = '{q: 0, d: 0, n: 0, inexact: 0, range: 0, shrt: 0};
    if (amt > MAX_CHANGE) begin
      r.range = 1'b1;
      lat = 2;
    end else begin
      rem = amt;
      r.q = imin(rem / 25, mdl_q); rem -= 25 * r.q;
      r.d = imin(rem / 10, mdl_d); rem -= 10 * r.d;
      r.n = imin(rem / 5,  mdl_n); rem -= 5 * r.n;
      mdl_q -= r.q; mdl_d -= r.d; mdl_n -= r.n;
      r.inexact = (rem > 0) && (rem < 5);
`ifdef INVENTORY_EN
      r.shrt = (rem >= 5);
`endif
      for (int i = 0; i < r.q; i++) exp_coins.push_back(2'b01);
      for (int i = 0; i < r.d; i++) exp_coins.push_back(2'b10);
      for (int i = 0; i < r.n; i++) exp_coins.push_back(2'b11);
      lat = 3;
    end
    exp_res.push_back(r);
  endtask

  // Coin mechanism: acks each request after a chosen delay, optionally pulses stray acks.
  initial begin
    int wc, cur;
    wc = 0; cur = 0;
    coin_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      coin_ack = 1'b0;
      if (coin_req) begin
        if (wc == 0) cur = (ack_dly < 0) ? int'($urandom_range(0, 4)) : ack_dly;
        if (wc >= cur) coin_ack = 1'b1;
        wc++;
      end else begin
        wc = 0;
        if (spurious) coin_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a coin request or a done pulse.
  logic       prev_req = 1'b0, prev_done = 1'b0;
  logic [1:0] held_sel = 2'b00;
  int         last_q = 0, last_d = 0, last_n = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_req  <= 1'b0;
      prev_done <= 1'b0;
    end else begin
      if (coin_req && !prev_req) begin
        if (exp_coins.size() == 0) fail("unexpected_coin_req");
        else begin
          check("coin_sel", coin_sel, exp_coins[0]);
          void'(exp_coins.pop_front());
        end
        held_sel <= coin_sel;
      end else if (coin_req) begin
        check("coin_sel_stable", coin_sel, held_sel);
      end else begin
        check("coin_sel_idle", coin_sel, 2'b00);
      end
      if (done) begin
        check("busy_at_done", busy, 0);
        if (exp_res.size() == 0) fail("unexpected_done");
        else begin
          check("quarters", quarters, exp_res[0].q);
          check("dimes", dimes, exp_res[0].d);
          check("nickels", nickels, exp_res[0].n);
          check("err_inexact", err_inexact, exp_res[0].inexact);
          check("err_range", err_range, exp_res[0].range);
          check("err_short", err_short, exp_res[0].shrt);
          check("coins_left", exp_coins.size(), 0);
          last_q <= exp_res[0].q;
          last_d <= exp_res[0].d;
          last_n <= exp_res[0].n;
          void'(exp_res.pop_front());
        end
      end
      if (prev_done) begin
        check("done_one_cycle", done, 0);
        check("quarters_hold", quarters, last_q);
        check("dimes_hold", dimes, last_d);
        check("nickels_hold", nickels, last_n);
      end
      prev_req  <= coin_req;
      prev_done <= done;
    end
  end

  // Called at the #1 phase after a rising edge; returns in the same phase.
  task automatic run_txn(input int amt, input int dly);
    int lat, k, t;
    ack_dly = dly;
    model_txn(amt, lat);
    start  = 1'b1;
    change = amt;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) check("busy_after_start", busy, 1);
    end while (!(coin_req || done) && k < 6);
    check("first_latency", k, lat);
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
      start  = spurious && coin_req && ($urandom_range(0, 3) == 0);
      change = $urandom_range(0, 200);
    end
    start = 1'b0;
    if (!done) fail("done_timeout");
    @(posedge clk);
    #1;
  endtask

`ifdef INVENTORY_EN
  task automatic load(input int q, input int d, input int n, input bit with_start);
    load_inv = 1'b1;
    start    = with_start;
    change   = 5;
    inv_q = q; inv_d = d; inv_n = n;
    @(posedge clk);
    #1 load_inv = 1'b0;
    start = 1'b0;
    mdl_q = q; mdl_d = d; mdl_n = n;
    @(negedge clk);
    check("busy_after_load", busy, 0);
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; change = '0; load_inv = 1'b0;
    inv_q = '0; inv_d = '0; inv_n = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_coin_req", coin_req, 0);
    check("rst_coin_sel", coin_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quarters", quarters, 0);
    check("rst_dimes", dimes, 0);
    check("rst_nickels", nickels, 0);
    check("rst_err_inexact", err_inexact, 0);
    check("rst_err_range", err_range, 0);
    check("rst_err_short", err_short, 0);
    @(posedge clk);
    #1;

`ifdef INVENTORY_EN
    load(255, 255, 255, 1'b0);
`endif
    run_txn(65, 0);
    run_txn(0, 0);
    run_txn(33, 0);
    run_txn(30, 6);
    run_txn(12776, 0);
    run_txn(4, 1);
`ifdef INVENTORY_EN
    load(255, 255, 255, 1'b0);
    run_txn(6375, 0);
`else
    run_txn(12775, 0);
`endif

    // Reset in the middle of a coin handshake.
`ifdef INVENTORY_EN
    load(255, 255, 255, 1'b0);
`endif
    ack_dly = 0;
    model_txn(65, t);
    start = 1'b1; change = 65;
    @(posedge clk);
    #1 start = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(coin_req && quarters == 1) && t < 50);
    if (t >= 50) fail("reset_setup_timeout");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_coins.delete();
    exp_res.delete();
    @(negedge clk);
    check("midrst_coin_req", coin_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_quarters", quarters, 0);
    check("midrst_dimes", dimes, 0);
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_done", done, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

`ifdef INVENTORY_EN
    load(1, 0, 10, 1'b1);
    run_txn(50, 0);
    load(0, 0, 1, 1'b0);
    run_txn(20, 0);
`endif

    ack_dly  = -1;
    spurious = 1'b1;
    for (int i = 0; i < 40; i++) begin
`ifdef INVENTORY_EN
      load($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12), 1'b0);
`endif
      if ($urandom_range(0, 9) == 0) run_txn($urandom_range(12770, 12800), -1);
      else run_txn($urandom_range(0, 400), -1);
    end
    spurious = 1'b0;
    repeat (3) @(posedge clk);
    check("exp_res_drained", exp_res.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
